// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode/funct/ALU encodings and decoder control bundle for ID and EX
package decode_stage_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_SUBU = 8'h23;
  localparam logic [7:0] ALU_SLL  = 8'h7C;
  localparam logic [7:0] ALU_SRL  = 8'h02;
  localparam logic [7:0] ALU_LW   = 8'hE3;
  localparam logic [7:0] ALU_SW   = 8'hEB;
  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_MEM   = 3'd4;
  typedef enum logic [1:0] {IMM_ZX, IMM_SX, IMM_LUI} imm_kind_e;
  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    imm_kind_e  imm_kind;
    logic       wreg;
    logic       rd_dst;
    logic       re1;
    logic       re2;
    logic       imm_op2;
    logic       shamt_op1;
    logic       is_load;
    logic       is_store;
    logic       invalid;
  } ctrl_t;
  function automatic ctrl_t nop_ctrl(input logic invalid);
    nop_ctrl = '0;
    nop_ctrl.aluop = ALU_NOP;
    nop_ctrl.alusel = SEL_NOP;
    nop_ctrl.imm_kind = IMM_ZX;
    nop_ctrl.invalid = invalid;
  endfunction
endpackage

// File: rtl/operand_fwd.sv
// operand_fwd: one ID operand, $0 -> 0, then EX, then MEM forwarding, else register file
//   addr_i/rf_data_i: register read address and data; ex_*/mem_*: forwarding sources; data_o: resolved operand
module operand_fwd #(
  parameter int DW = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] addr_i,
  input  logic [DW-1:0]  rf_data_i,
  input  logic           ex_wreg_i,
  input  logic [RAW-1:0] ex_waddr_i,
  input  logic [DW-1:0]  ex_wdata_i,
  input  logic           mem_wreg_i,
  input  logic [RAW-1:0] mem_waddr_i,
  input  logic [DW-1:0]  mem_wdata_i,
  output logic [DW-1:0]  data_o
);
  assign data_o = addr_i == '0 ? '0 :
                  (ex_wreg_i && ex_waddr_i == addr_i) ? ex_wdata_i :
                  (mem_wreg_i && mem_waddr_i == addr_i) ? mem_wdata_i : rf_data_i;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS-subset instruction decode with operand forwarding, load-use detection and ID/EX register
//   pc_i/inst_i: instruction in ID; rf_*: register-file read port; ex_*_i/mem_*_i: forwarding sources;
//   stall_i/flush_i: pipeline control; stall_req_o: load-use hazard; ex_*_o: registered ID/EX outputs
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  pc_i,
  input  logic [31:0]    inst_i,
  input  logic [DW-1:0]  rf_rdata1_i,
  input  logic [DW-1:0]  rf_rdata2_i,
  output logic [RAW-1:0] rf_raddr1_o,
  output logic [RAW-1:0] rf_raddr2_o,
  output logic           rf_re1_o,
  output logic           rf_re2_o,
  input  logic           ex_wreg_i,
  input  logic [RAW-1:0] ex_waddr_i,
  input  logic [DW-1:0]  ex_wdata_i,
  input  logic           ex_is_load_i,
  input  logic           mem_wreg_i,
  input  logic [RAW-1:0] mem_waddr_i,
  input  logic [DW-1:0]  mem_wdata_i,
  input  logic           stall_i,
  input  logic           flush_i,
  output logic           stall_req_o,
  output logic [7:0]     ex_aluop_o,
  output logic [2:0]     ex_alusel_o,
  output logic [DW-1:0]  ex_op1_o,
  output logic [DW-1:0]  ex_op2_o,
  output logic [RAW-1:0] ex_waddr_o,
  output logic           ex_wreg_o,
  output logic           ex_is_load_o,
  output logic [DW-1:0]  ex_store_data_o,
  output logic [DW-1:0]  ex_pc_o,
  output logic           ex_inst_invalid_o
);
  typedef struct packed {
    logic [7:0]     aluop;
    logic [2:0]     alusel;
    logic [DW-1:0]  op1;
    logic [DW-1:0]  op2;
    logic [RAW-1:0] waddr;
    logic           wreg;
    logic           is_load;
    logic [DW-1:0]  store_data;
    logic [DW-1:0]  pc;
    logic           invalid;
  } idex_t;
  ctrl_t c;
  idex_t dec, bubble, idex_d, idex_q;
  logic [DW-1:0] imm, fwd1, fwd2, imm_sx;
  logic [RAW-1:0] waddr;
  always_comb begin
    c = nop_ctrl(1'b0);
    case (inst_i[31:26])
      OP_ORI: begin
        {c.aluop, c.alusel} = {ALU_OR, SEL_LOGIC};
        {c.wreg, c.re1, c.imm_op2} = 3'b111;
      end
      OP_ANDI: begin
        {c.aluop, c.alusel} = {ALU_AND, SEL_LOGIC};
        {c.wreg, c.re1, c.imm_op2} = 3'b111;
      end
      OP_XORI: begin
        {c.aluop, c.alusel} = {ALU_XOR, SEL_LOGIC};
        {c.wreg, c.re1, c.imm_op2} = 3'b111;
      end
      OP_ADDIU: begin
        {c.aluop, c.alusel} = {ALU_ADDU, SEL_ARITH};
        {c.wreg, c.re1, c.imm_op2} = 3'b111;
        c.imm_kind = IMM_SX;
      end
      OP_LUI: begin
        {c.aluop, c.alusel} = {ALU_OR, SEL_LOGIC};
        {c.wreg, c.imm_op2} = 2'b11;
        c.imm_kind = IMM_LUI;
      end
      OP_LW: begin
        {c.aluop, c.alusel} = {ALU_LW, SEL_MEM};
        {c.wreg, c.re1, c.imm_op2, c.is_load} = 4'b1111;
        c.imm_kind = IMM_SX;
      end
      OP_SW: begin
        {c.aluop, c.alusel} = {ALU_SW, SEL_MEM};
        {c.re1, c.re2, c.imm_op2, c.is_store} = 4'b1111;
        c.imm_kind = IMM_SX;
      end
      OP_SPECIAL: begin
        {c.wreg, c.rd_dst, c.re1, c.re2} = 4'b1111;
        case (inst_i[5:0])
          FN_AND:  {c.aluop, c.alusel} = {ALU_AND, SEL_LOGIC};
          FN_OR:   {c.aluop, c.alusel} = {ALU_OR, SEL_LOGIC};
          FN_XOR:  {c.aluop, c.alusel} = {ALU_XOR, SEL_LOGIC};
          FN_NOR:  {c.aluop, c.alusel} = {ALU_NOR, SEL_LOGIC};
          FN_ADDU: {c.aluop, c.alusel} = {ALU_ADDU, SEL_ARITH};
          FN_SUBU: {c.aluop, c.alusel} = {ALU_SUBU, SEL_ARITH};
          FN_SLL: begin
            {c.aluop, c.alusel} = {ALU_SLL, SEL_SHIFT};
            {c.re1, c.shamt_op1} = 2'b01;
          end
          FN_SRL: begin
            {c.aluop, c.alusel} = {ALU_SRL, SEL_SHIFT};
            {c.re1, c.shamt_op1} = 2'b01;
          end
          default: c = nop_ctrl(1'b1);
        endcase
      end
      default: c = nop_ctrl(1'b1);
    endcase
  end
  assign rf_raddr1_o = RAW'(inst_i[25:21]);
  assign rf_raddr2_o = RAW'(inst_i[20:16]);
  assign rf_re1_o = c.re1;
  assign rf_re2_o = c.re2;
  assign waddr = c.rd_dst ? RAW'(inst_i[15:11]) : RAW'(inst_i[20:16]);
  // Shifting the sign-extended value keeps bit 31 replicated above it when DW > 32
  assign imm_sx = {{(DW-16){inst_i[15]}}, inst_i[15:0]};
  assign imm = c.imm_kind == IMM_LUI ? imm_sx << 16 :
               c.imm_kind == IMM_SX ? imm_sx : {{(DW-16){1'b0}}, inst_i[15:0]};
  assign stall_req_o = ex_is_load_i && ex_wreg_i && ex_waddr_i != '0 &&
                       ((c.re1 && ex_waddr_i == rf_raddr1_o) || (c.re2 && ex_waddr_i == rf_raddr2_o));
  operand_fwd #(.DW(DW), .RAW(RAW)) u_fwd1 (
    .addr_i(rf_raddr1_o), .rf_data_i(rf_rdata1_i),
    .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .data_o(fwd1)
  );
  operand_fwd #(.DW(DW), .RAW(RAW)) u_fwd2 (
    .addr_i(rf_raddr2_o), .rf_data_i(rf_rdata2_i),
    .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .data_o(fwd2)
  );
  always_comb begin
    bubble = '0;
    bubble.aluop = ALU_NOP;
    bubble.alusel = SEL_NOP;
    dec.aluop = c.aluop;
    dec.alusel = c.alusel;
    dec.op1 = c.shamt_op1 ? DW'(inst_i[10:6]) : c.re1 ? fwd1 : '0;
    dec.op2 = c.imm_op2 ? imm : c.re2 ? fwd2 : '0;
    dec.waddr = waddr;
    dec.wreg = c.wreg && waddr != '0;
    dec.is_load = c.is_load;
    dec.store_data = c.is_store ? fwd2 : '0;
    dec.pc = pc_i;
    dec.invalid = c.invalid;
    idex_d = flush_i ? bubble : stall_i ? idex_q : stall_req_o ? bubble : dec;
  end
  always_ff @(posedge clk) idex_q <= rst ? bubble : idex_d;
  assign ex_aluop_o = idex_q.aluop;
  assign ex_alusel_o = idex_q.alusel;
  assign ex_op1_o = idex_q.op1;
  assign ex_op2_o = idex_q.op2;
  assign ex_waddr_o = idex_q.waddr;
  assign ex_wreg_o = idex_q.wreg;
  assign ex_is_load_o = idex_q.is_load;
  assign ex_store_data_o = idex_q.store_data;
  assign ex_pc_o = idex_q.pc;
  assign ex_inst_invalid_o = idex_q.invalid;
endmodule
